// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding and
// per-boundary payload widths/field offsets used to pack stage payloads.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;

  // ID/EX payload, fields packed LSB first
  localparam int unsigned IDEX_PC_OFF     = 0;
  localparam int unsigned IDEX_RS1_OFF    = IDEX_PC_OFF + XLEN;
  localparam int unsigned IDEX_RS2_OFF    = IDEX_RS1_OFF + XLEN;
  localparam int unsigned IDEX_IMM_OFF    = IDEX_RS2_OFF + XLEN;
  localparam int unsigned IDEX_RD_OFF     = IDEX_IMM_OFF + XLEN;
  localparam int unsigned IDEX_ALUOP_OFF  = IDEX_RD_OFF + REG_W;
  localparam int unsigned IDEX_ALUOP_W    = 4;
  localparam int unsigned IDEX_CTRL_OFF   = IDEX_ALUOP_OFF + IDEX_ALUOP_W;
  localparam int unsigned IDEX_CTRL_W     = 8;
  localparam int unsigned IDEX_W          = IDEX_CTRL_OFF + IDEX_CTRL_W;

  // EX/MEM payload
  localparam int unsigned EXMEM_PC_OFF    = 0;
  localparam int unsigned EXMEM_ALU_OFF   = EXMEM_PC_OFF + XLEN;
  localparam int unsigned EXMEM_STD_OFF   = EXMEM_ALU_OFF + XLEN;
  localparam int unsigned EXMEM_RD_OFF    = EXMEM_STD_OFF + XLEN;
  localparam int unsigned EXMEM_CTRL_OFF  = EXMEM_RD_OFF + REG_W;
  localparam int unsigned EXMEM_CTRL_W    = 8;
  localparam int unsigned EXMEM_W         = EXMEM_CTRL_OFF + EXMEM_CTRL_W;

  // MEM/WB payload
  localparam int unsigned MEMWB_RES_OFF   = 0;
  localparam int unsigned MEMWB_RD_OFF    = MEMWB_RES_OFF + XLEN;
  localparam int unsigned MEMWB_CTRL_OFF  = MEMWB_RD_OFF + REG_W;
  localparam int unsigned MEMWB_CTRL_W    = 4;
  localparam int unsigned MEMWB_W         = MEMWB_CTRL_OFF + MEMWB_CTRL_W;

  // The state encoding doubles as the held-beat count.
  function automatic logic [1:0] occ_of(input pipe_state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_stat_ctr.sv
// Saturating up-counter with enable; clears only on asynchronous reset.
module pipe_stat_ctr #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with one-entry skid buffer and flush.
// Optional saturating stall/flush counters under PIPE_STAGE_SKID_STATS_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = 128,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int unsigned       STAT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_SKID_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_count
`endif
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              in_fire, out_fire;
  logic              load_main, main_from_skid, load_skid;

  // in_ready depends on registered state only, so stalls break here.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        unique case ({in_fire, out_fire})
          2'b11: load_main = 1'b1;
          2'b10: begin
            state_d   = FULL;
            load_skid = 1'b1;
          end
          2'b01: state_d = EMPTY;
          default: state_d = ONE;
        endcase
      end
      FULL: begin
        if (out_fire) begin
          state_d        = ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else if (flush) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : in_data;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_SKID_STATS_EN
  pipe_stat_ctr #(.W(STAT_W)) u_stall_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (out_valid & ~out_ready),
    .count (stall_cycles)
  );

  pipe_stat_ctr #(.W(STAT_W)) u_flush_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (flush & (state_q != EMPTY)),
    .count (flush_count)
  );
`endif

endmodule
